// File: rtl/uart_tx_serializer.sv
// Byte-wide UART transmitter: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// One byte per tx_start/tx_busy handshake; tx, tx_busy and tx_done are all registered.
module uart_tx_serializer #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115_200,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int unsigned BAUD_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(BAUD_DIV - 2);
  localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              tx_d, tx_busy_d, tx_done_d;
  logic              baud_end;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx         <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx         <= tx_d;
      tx_busy    <= tx_busy_d;
      tx_done    <= tx_done_d;
    end
  end

  // Next-state logic; tx_d is the level of the bit entered on this edge so tx only moves at bit boundaries
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    tx_d       = tx;
    tx_done_d  = 1'b0;
    baud_end   = (baud_cnt_q == BAUD_LAST);

    case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        bit_cnt_d  = '0;
        tx_d       = 1'b1;
        if (tx_start) begin
          shift_d  = tx_data;
          parity_d = (PARITY == 2) ? ~^tx_data : ^tx_data;
          state_d  = S_START;
          tx_d     = 1'b0;
        end
      end
      S_START: begin
        baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        if (baud_end) begin
          baud_cnt_d = '0;
          state_d    = S_DATA;
          tx_d       = shift_q[0];
        end
      end
      S_DATA: begin
        baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        if (baud_end) begin
          baud_cnt_d = '0;
          state_d    = S_STOP;
          tx_d       = 1'b1;
        end
      end
      S_STOP: begin
        baud_cnt_d = baud_cnt_q + BAUD_W'(1);
        // Registered pulse must be armed one cycle ahead to land in the final stop cycle
        if (bit_cnt_q == STOP_LAST && baud_cnt_q == BAUD_PRE) begin
          tx_done_d = 1'b1;
        end
        if (baud_end) begin
          baud_cnt_d = '0;
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            state_d   = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    tx_busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four parity/stop configurations driven in parallel,
// each output stream compared cycle by cycle against a frame-layout reference model.
module tb_uart_tx_serializer;

  localparam int DIV = 10;
  localparam int PAR_CFG [4] = '{0, 1, 2, 1};
  localparam int STP_CFG [4] = '{1, 1, 1, 2};

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] tx_w, busy_w, done_w;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(busy_w[0]), .tx_done(done_w[0]), .tx(tx_w[0]));
  uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(busy_w[1]), .tx_done(done_w[1]), .tx(tx_w[1]));
  uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(busy_w[2]), .tx_done(done_w[2]), .tx(tx_w[2]));
  uart_tx_serializer #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY(1), .STOP_BITS(2)) dut3 (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(busy_w[3]), .tx_done(done_w[3]), .tx(tx_w[3]));

  // Reference model: frame length and the line level in cycle k (1 = first cycle after accept)
  function automatic int frame_len(int c);
    return (9 + ((PAR_CFG[c] != 0) ? 1 : 0) + STP_CFG[c]) * DIV;
  endfunction

  function automatic logic exp_bit(int c, logic [7:0] b, int k);
    int slot;
    int ones;
    slot = (k - 1) / DIV;
    ones = $countones(b);
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (slot == 9 && PAR_CFG[c] == 1) return (ones % 2) == 1;
    if (slot == 9 && PAR_CFG[c] == 2) return (ones % 2) == 0;
    return 1'b1;
  endfunction

  // Expected {tx, tx_busy, tx_done}
  function automatic logic [2:0] exp_out(int c, logic [7:0] b, int k);
    int len;
    len = frame_len(c);
    if (k > len) return 3'b100;
    return {exp_bit(c, b, k), 1'b1, k == len};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    tx_start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [2:0] obs;
    reset    = 1'b1;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      obs = {tx_w[c], busy_w[c], done_w[c]};
      n_vec++;
      if (obs !== 3'b100) begin
        n_err++;
        $display("FAIL reset_hold dut%0d {tx,busy,done}=%b expected=%b", c, obs, 3'b100);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      obs = {tx_w[c], busy_w[c], done_w[c]};
      n_vec++;
      if (obs !== 3'b100) begin
        n_err++;
        $display("FAIL reset_release dut%0d {tx,busy,done}=%b expected=%b", c, obs, 3'b100);
      end
    end
  endtask

  task automatic test_frames();
    logic [7:0] bytes [6];
    logic [2:0] obs, exp;
    bytes[0] = 8'h55;
    bytes[1] = 8'h07;
    for (int i = 2; i < 6; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tx_data  = bytes[i];
      tx_start = 1'b1;
      for (int k = 1; k <= 123; k++) begin
        @(negedge clk);
        tx_start = 1'b0;
        for (int c = 0; c < 4; c++) begin
          obs = {tx_w[c], busy_w[c], done_w[c]};
          exp = exp_out(c, bytes[i], k);
          n_vec++;
          if (obs !== exp) begin
            n_err++;
            $display("FAIL frame dut%0d byte=%h k=%0d {tx,busy,done}=%b expected=%b",
                     c, bytes[i], k, obs, exp);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] obs, exp;
    do_reset();
    @(negedge clk);
    tx_data  = 8'hA3;
    tx_start = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      obs = {tx_w[0], busy_w[0], done_w[0]};
      exp = exp_out(0, 8'hA3, k);
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL b2b_frame1 k=%0d {tx,busy,done}=%b expected=%b", k, obs, exp);
      end
    end
    // busy just fell with tx_start still high: this cycle accepts the second byte
    tx_data = 8'h3C;
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      tx_start = 1'b0;
      obs = {tx_w[0], busy_w[0], done_w[0]};
      exp = exp_out(0, 8'h3C, k);
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL b2b_frame2 k=%0d {tx,busy,done}=%b expected=%b", k, obs, exp);
      end
    end
    do_reset();
  endtask

  task automatic test_ignore_busy();
    logic [7:0] b;
    logic [2:0] obs, exp;
    b = 8'($urandom);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        obs = {tx_w[c], busy_w[c], done_w[c]};
        exp = exp_out(c, b, k);
        n_vec++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL ignore_busy dut%0d byte=%h k=%0d {tx,busy,done}=%b expected=%b",
                   c, b, k, obs, exp);
        end
      end
      if (k <= 90) begin
        tx_data  = 8'($urandom);
        tx_start = 1'($urandom);
      end else begin
        tx_start = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b, b2;
    logic [2:0] obs, exp;
    b  = 8'($urandom);
    b2 = 8'($urandom);
    @(negedge clk);
    tx_data  = b;
    tx_start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      tx_start = 1'b0;
      for (int c = 0; c < 4; c++) begin
        obs = {tx_w[c], busy_w[c], done_w[c]};
        exp = (k <= 35) ? exp_out(c, b, k) : 3'b100;
        n_vec++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL reset_mid dut%0d k=%0d {tx,busy,done}=%b expected=%b", c, k, obs, exp);
        end
      end
      reset = (k == 35);
    end
    @(negedge clk);
    tx_data  = b2;
    tx_start = 1'b1;
    for (int k = 1; k <= 123; k++) begin
      @(negedge clk);
      tx_start = 1'b0;
      for (int c = 0; c < 4; c++) begin
        obs = {tx_w[c], busy_w[c], done_w[c]};
        exp = exp_out(c, b2, k);
        n_vec++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL after_reset dut%0d k=%0d {tx,busy,done}=%b expected=%b", c, k, obs, exp);
        end
      end
    end
  endtask

  task automatic test_reset_with_start();
    logic [2:0] obs;
    @(negedge clk);
    reset    = 1'b1;
    tx_start = 1'b1;
    tx_data  = 8'($urandom);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      reset    = 1'b0;
      tx_start = 1'b0;
      for (int c = 0; c < 4; c++) begin
        obs = {tx_w[c], busy_w[c], done_w[c]};
        n_vec++;
        if (obs !== 3'b100) begin
          n_err++;
          $display("FAIL reset_with_start dut%0d k=%0d {tx,busy,done}=%b expected=%b",
                   c, k, obs, 3'b100);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
    test_reset_with_start();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
